// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration owner state and
// the read-return owner tag.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_EXT  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_CPU  = 2'd1,
      RD_EXT  = 2'd2
   } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_rr_grant.sv
// Combinational round-robin grant with a burst cap: the last owner keeps the
// memory until it has taken MAX_BURST back-to-back grants while the other waits.
module dmem_arbiter_rr_grant
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BCNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic              cpu_req_i,
   input  logic              ext_req_i,
   input  logic [1:0]        state_i,
   input  logic [BCNT_W-1:0] burst_cnt_i,
   output logic              cpu_gnt_o,
   output logic              ext_gnt_o
);

   logic under_cap;

   always_comb begin
      under_cap = (burst_cnt_i < BCNT_W'(MAX_BURST));
      cpu_gnt_o = 1'b0;
      ext_gnt_o = 1'b0;
      case (arb_state_t'(state_i))
         ARB_CPU: begin
            cpu_gnt_o = cpu_req_i & (~ext_req_i | under_cap);
            ext_gnt_o = ext_req_i & ~cpu_gnt_o;
         end
         ARB_EXT: begin
            ext_gnt_o = ext_req_i & (~cpu_req_i | under_cap);
            cpu_gnt_o = cpu_req_i & ~ext_gnt_o;
         end
         default: begin
            cpu_gnt_o = cpu_req_i;
            ext_gnt_o = ext_req_i & ~cpu_req_i;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and an
// external (debug/loader) port; one access per cycle, read data returned next cycle.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BCNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state_q;
   logic [BCNT_W-1:0] burst_cnt_q;
   rd_owner_t         rd_owner_q;
   logic              cpu_win;
   logic              ext_win;

   function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] cnt);
      return (cnt >= BCNT_W'(MAX_BURST)) ? cnt : cnt + BCNT_W'(1);
   endfunction

   dmem_arbiter_rr_grant #(
      .MAX_BURST (MAX_BURST),
      .BCNT_W    (BCNT_W)
   ) u_rr_grant (
      .cpu_req_i   (cpu_req),
      .ext_req_i   (ext_req),
      .state_i     (state_q),
      .burst_cnt_i (burst_cnt_q),
      .cpu_gnt_o   (cpu_win),
      .ext_gnt_o   (ext_win)
   );

   // Grants are combinational, so they are masked directly while reset is held.
   assign cpu_gnt   = cpu_win & ~RST;
   assign ext_gnt   = ext_win & ~RST;
   assign cpu_stall = cpu_req & ~cpu_gnt & ~RST;

   assign mem_addr  = cpu_gnt ? cpu_addr  : (ext_gnt ? ext_addr  : '0);
   assign mem_wdata = cpu_gnt ? cpu_wdata : (ext_gnt ? ext_wdata : '0);
   assign mem_we    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ARB_IDLE;
         burst_cnt_q <= '0;
         rd_owner_q  <= RD_NONE;
      end else begin
         rd_owner_q  <= RD_NONE;
         burst_cnt_q <= '0;
         if (cpu_gnt) begin
            state_q     <= ARB_CPU;
            burst_cnt_q <= (state_q == ARB_CPU) ? sat_inc(burst_cnt_q) : BCNT_W'(1);
            if (!cpu_we) rd_owner_q <= RD_CPU;
         end else if (ext_gnt) begin
            state_q     <= ARB_EXT;
            burst_cnt_q <= (state_q == ARB_EXT) ? sat_inc(burst_cnt_q) : BCNT_W'(1);
            if (!ext_we) rd_owner_q <= RD_EXT;
         end
      end
   end

   assign cpu_rvalid = (rd_owner_q == RD_CPU);
   assign ext_rvalid = (rd_owner_q == RD_EXT);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a memory model, a transaction-level arbitration model
// compared every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MB = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          ext_req = 1'b0, ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, mem_we;
   logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] tmem [0:(1<<AW)-1];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: last owner (0 none, 1 cpu, 2 ext), its run length,
   // and the port/data of a read due next cycle.
   int            m_owner = 0;
   int            m_run   = 0;
   int            m_rd    = 0;
   logic [DW-1:0] m_rdat  = '0;

   always #5 CLK = ~CLK;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .CLK(CLK), .RST(RST),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always @(posedge CLK) begin
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      mem_rdata <= tmem[mem_addr];
   end

   // Who should win this cycle: a lone requester always wins; on a tie the CPU
   // wins from idle, otherwise the last owner wins unless it has used up its burst.
   function automatic int pick(input logic c, input logic e);
      if (!c && !e) return 0;
      if (c && !e)  return 1;
      if (e && !c)  return 2;
      if (m_owner == 0) return 1;
      if (m_run >= MB) return (m_owner == 1) ? 2 : 1;
      return m_owner;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_owner <= 0;
         m_run   <= 0;
         m_rd    <= 0;
      end else begin
         case (pick(cpu_req, ext_req))
            1: begin
               m_run   <= (m_owner == 1) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
               m_owner <= 1;
               m_rd    <= cpu_we ? 0 : 1;
               m_rdat  <= tmem[cpu_addr];
            end
            2: begin
               m_run   <= (m_owner == 2) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
               m_owner <= 2;
               m_rd    <= ext_we ? 0 : 2;
               m_rdat  <= tmem[ext_addr];
            end
            default: begin
               m_run <= 0;
               m_rd  <= 0;
            end
         endcase
      end
   end

   always @(negedge CLK) begin : cmp
      int            g;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      g  = RST ? 0 : pick(cpu_req, ext_req);
      ea = (g == 1) ? cpu_addr  : ((g == 2) ? ext_addr  : '0);
      ed = (g == 1) ? cpu_wdata : ((g == 2) ? ext_wdata : '0);
      ew = (g == 1) ? cpu_we    : ((g == 2) ? ext_we    : 1'b0);
      chk("model_gnt",    64'({cpu_gnt, ext_gnt}), 64'({g == 1, g == 2}));
      chk("model_stall",  64'(cpu_stall), 64'(cpu_req && !RST && g != 1));
      chk("model_mem",    64'({mem_addr, mem_wdata, mem_we}), 64'({ea, ed, ew}));
      chk("model_rvalid", 64'({cpu_rvalid, ext_rvalid}), 64'({m_rd == 1, m_rd == 2}));
      chk("model_rdata",  64'({cpu_rdata, ext_rdata}),
          64'({(m_rd == 1) ? m_rdat : 16'h0, (m_rd == 2) ? m_rdat : 16'h0}));
   end

   task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
      @(posedge CLK);
      #1;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
      @(negedge CLK);
   endtask

   task automatic idle();
      step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic pulse_rst();
      @(posedge CLK);
      #1;
      RST = 1'b1;
      cpu_req = 0; ext_req = 0; cpu_we = 0; ext_we = 0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   logic [11:0] pat, stl;
   logic [4:0]  ep;

   initial begin
      // A CPU request held during reset must not leak out as a grant or stall.
      cpu_req = 1'b1;
      @(negedge CLK);
      chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
      chk("rst_stall",   64'(cpu_stall), 64'd0);
      chk("rst_mem",     64'({mem_addr, mem_we}), 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      cpu_req = 1'b0;

      // Load memory contents through the external port.
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
      chk("pre_ext_gnt", 64'(ext_gnt), 64'd1);
      chk("pre_mem",     64'({mem_addr, mem_wdata, mem_we}), 64'({16'h0010, 16'hBEEF, 1'b1}));
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0001, 16'h1111);
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0002, 16'h2222);
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0003, 16'h3333);

      // CPU read right after reset.
      pulse_rst();
      step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("t1_cpu_gnt", 64'(cpu_gnt), 64'd1);
      idle();
      chk("t1_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
      chk("t1_cpu_rdata",  64'(cpu_rdata), 64'hBEEF);
      chk("t1_ext_rvalid", 64'(ext_rvalid), 64'd0);

      // Both ports requesting continuously: bursts of four.
      pulse_rst();
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0);
         pat[11-i] = cpu_gnt;
         stl[11-i] = cpu_stall;
      end
      chk("t2_pattern", 64'(pat), 64'hF0F);
      chk("t2_stall",   64'(stl), 64'h0F0);
      idle();

      // CPU write then external read of the same address.
      step(1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0, 16'h0);
      chk("t3_we_on", 64'(mem_we), 64'd1);
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
      chk("t3_we_off",  64'(mem_we), 64'd0);
      chk("t3_ext_gnt", 64'(ext_gnt), 64'd1);
      idle();
      chk("t3_ext_rd", 64'({ext_rvalid, ext_rdata, cpu_rvalid}), 64'({1'b1, 16'h1234, 1'b0}));

      // Alternating reads land on the right port.
      step(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0);
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0);
      chk("t4_cpu1", 64'({cpu_rvalid, cpu_rdata, ext_rvalid}), 64'({1'b1, 16'h1111, 1'b0}));
      step(1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("t4_ext2", 64'({ext_rvalid, ext_rdata, cpu_rvalid}), 64'({1'b1, 16'h2222, 1'b0}));
      idle();
      chk("t4_cpu3", 64'({cpu_rvalid, cpu_rdata, ext_rvalid}), 64'({1'b1, 16'h3333, 1'b0}));

      // Reset while a CPU read is pending drops its rvalid; CPU wins tie after release.
      step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      cpu_req = 0; ext_req = 0;
      #1;
      chk("t5_rvalid_dropped", 64'(cpu_rvalid), 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
      ext_req = 1; ext_we = 0; ext_addr = 16'h0002;
      @(negedge CLK);
      chk("t5_tie_cpu", 64'({cpu_gnt, ext_gnt}), 64'b10);

      // Idle cycles clear the burst count: EXT keeps a full burst of four.
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0);
      idle();
      idle();
      idle();
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0);
         ep[4-i] = ext_gnt;
      end
      chk("t6_ext_burst", 64'(ep), 64'b11110);
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
